// File: rtl/vector_sequencer.sv
// ---------------------------------------------------------------------------
// vector_sequencer
//
// Test-vector player/checker for the datapath control word. A loadable table
// of {stimulus, expected, mask} entries is replayed in order. Each vector's
// stimulus is driven for LATENCY+1 cycles. The DUT result is compared under
// the mask in the last of those cycles. The block counts mismatches with a
// saturating counter and captures the index of the first failing vector.
//
// Optional build macro:
//   VECTOR_SEQUENCER_STOP_ON_ERROR_EN - when defined, the first mismatch ends
//   the run immediately and leaves VectorIdx at the failing vector.
//
// Ports:
//   Clock          rising-edge clock
//   Reset          synchronous, active-low
//   LoadEn         write one table entry this cycle (ignored while Busy)
//   LoadAddr       table write address
//   LoadData       {stim, expected, mask}, stim in the MSBs
//   NumVectors     vectors to run, sampled at Start (clamped to DEPTH)
//   Start          single-cycle run request (ignored while Busy)
//   Observed       DUT result under check
//   Stim           stimulus to the DUT
//   StimValid      high on the first cycle of each vector
//   Busy           run in progress
//   Done           run finished (sticky until next Start or reset)
//   VectorIdx      index of the current vector
//   ErrorCount     mismatches in the current/last run (saturating)
//   FirstFailValid at least one mismatch recorded
//   FirstFailIdx   index of the first mismatch
// ---------------------------------------------------------------------------
module vector_sequencer #(
    parameter int unsigned STIM_W  = 34,
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      LoadEn,
    input  logic [AW-1:0]             LoadAddr,
    input  logic [STIM_W+2*EXP_W-1:0] LoadData,
    input  logic [AW:0]               NumVectors,
    input  logic                      Start,
    input  logic [EXP_W-1:0]          Observed,
    output logic [STIM_W-1:0]         Stim,
    output logic                      StimValid,
    output logic                      Busy,
    output logic                      Done,
    output logic [AW-1:0]             VectorIdx,
    output logic [CNT_W-1:0]          ErrorCount,
    output logic                      FirstFailValid,
    output logic [AW-1:0]             FirstFailIdx
);

    localparam int unsigned ENTRY_W = STIM_W + 2 * EXP_W;
    // Wait counter only has to reach LATENCY-2.
    localparam int unsigned WW      = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        n_q, n_d;
    logic [STIM_W-1:0]  stim_q, stim_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               ffv_q, ffv_d;
    logic [AW-1:0]      ffi_q, ffi_d;

    logic [ENTRY_W-1:0] table_q [DEPTH];

    logic [ENTRY_W-1:0] entry;
    logic [STIM_W-1:0]  entry_stim;
    logic [EXP_W-1:0]   entry_exp;
    logic [EXP_W-1:0]   entry_mask;
    logic               mismatch;
    logic               last_vec;

    assign entry      = table_q[idx_q];
    assign entry_stim = entry[ENTRY_W-1 -: STIM_W];
    assign entry_exp  = entry[2*EXP_W-1 -: EXP_W];
    assign entry_mask = entry[EXP_W-1:0];
    assign mismatch   = |((Observed ^ entry_exp) & entry_mask);
    assign last_vec   = ({1'b0, idx_q} == (n_q - (AW + 1)'(1)));

    // Table is only writable outside a run, so the combinational read in
    // APPLY/CHECK always sees a stable entry. Contents survive reset.
    always_ff @(posedge Clock) begin
        if (LoadEn && ((state_q == IDLE) || (state_q == DONE))) begin
            table_q[LoadAddr] <= LoadData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            stim_q    <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            stim_q    <= stim_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        stim_d    = stim_q;
        wait_d    = wait_q;
        err_cnt_d = err_cnt_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    n_d       = (NumVectors > DEPTH_N) ? DEPTH_N : NumVectors;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    ffv_d     = 1'b0;
                    ffi_d     = '0;
                    state_d   = (NumVectors == '0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                // Capture the stimulus so it stays put through WAIT/CHECK.
                stim_d  = entry_stim;
                wait_d  = '0;
                state_d = (LATENCY == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                if (wait_q == WW'(LATENCY - 2)) begin
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end
`ifdef VECTOR_SEQUENCER_STOP_ON_ERROR_EN
                if (mismatch || last_vec) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = APPLY;
                end
`else
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = APPLY;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // In APPLY the table is read directly so the new vector appears on the
    // same cycle it is applied; afterwards the captured copy is held.
    assign Stim           = (state_q == APPLY) ? entry_stim : stim_q;
    assign StimValid      = (state_q == APPLY);
    assign Busy           = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign Done           = (state_q == DONE);
    assign VectorIdx      = idx_q;
    assign ErrorCount     = err_cnt_q;
    assign FirstFailValid = ffv_q;
    assign FirstFailIdx   = ffi_q;

endmodule

// File: tb/tb_vector_sequencer.sv
`timescale 1ns/1ps
module tb_vector_sequencer;

    localparam int unsigned STIM_W  = 34;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = STIM_W + 2 * EXP_W;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic                Clock = 1'b0;
    logic                Reset = 1'b0;
    logic                LoadEn = 1'b0;
    logic [AW-1:0]       LoadAddr = '0;
    logic [ENTRY_W-1:0]  LoadData = '0;
    logic [AW:0]         NumVectors = '0;
    logic                Start = 1'b0;
    logic [EXP_W-1:0]    Observed = '0;
    logic [STIM_W-1:0]   Stim;
    logic                StimValid;
    logic                Busy;
    logic                Done;
    logic [AW-1:0]       VectorIdx;
    logic [CNT_W-1:0]    ErrorCount;
    logic                FirstFailValid;
    logic [AW-1:0]       FirstFailIdx;

    always #5 Clock = ~Clock;

    vector_sequencer #(
        .STIM_W (STIM_W),
        .EXP_W  (EXP_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY),
        .CNT_W  (CNT_W)
    ) u_dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .LoadEn        (LoadEn),
        .LoadAddr      (LoadAddr),
        .LoadData      (LoadData),
        .NumVectors    (NumVectors),
        .Start         (Start),
        .Observed      (Observed),
        .Stim          (Stim),
        .StimValid     (StimValid),
        .Busy          (Busy),
        .Done          (Done),
        .VectorIdx     (VectorIdx),
        .ErrorCount    (ErrorCount),
        .FirstFailValid(FirstFailValid),
        .FirstFailIdx  (FirstFailIdx)
    );

    int checks = 0;
    int errors = 0;

    // Reference copy of the table plus the value the emulated DUT returns
    // for each vector in its compare cycle.
    logic [STIM_W-1:0] m_stim   [DEPTH];
    logic [EXP_W-1:0]  m_exp    [DEPTH];
    logic [EXP_W-1:0]  m_mask   [DEPTH];
    logic [EXP_W-1:0]  obs_good [DEPTH];

    function automatic logic [STIM_W-1:0] rand_stim();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[STIM_W-1:0];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int a, input logic [STIM_W-1:0] s,
                        input logic [EXP_W-1:0] e, input logic [EXP_W-1:0] m);
        LoadEn   = 1'b1;
        LoadAddr = AW'(a);
        LoadData = {s, e, m};
        tick();
        LoadEn   = 1'b0;
        m_stim[a] = s;
        m_exp[a]  = e;
        m_mask[a] = m;
    endtask

    // One complete run checked cycle by cycle against the timing rules:
    // vector v occupies cycles v*(L+1) .. v*(L+1)+L after the Start edge,
    // is applied in its first cycle and compared in its last.
    task automatic run(input int nv, input bit load_with_start,
                       input bit poke_busy, input int abort_at);
        int n, last, total, v, p, run_err, ff_idx, sat;
        bit ff_valid;
        bit err_v [DEPTH];
        logic [STIM_W-1:0] s;
        logic [EXP_W-1:0]  e, m;

        NumVectors = (AW + 1)'(nv);
        Start      = 1'b1;
        if (load_with_start) begin
            s = rand_stim();
            e = EXP_W'($urandom());
            m = EXP_W'($urandom());
            LoadEn    = 1'b1;
            LoadAddr  = '0;
            LoadData  = {s, e, m};
            m_stim[0] = s;
            m_exp[0]  = e;
            m_mask[0] = m;
        end
        tick();
        Start  = 1'b0;
        LoadEn = 1'b0;

        n    = (nv > DEPTH) ? DEPTH : nv;
        last = n - 1;
        for (int i = 0; i < DEPTH; i++) begin
            err_v[i] = (i < n) && (((obs_good[i] ^ m_exp[i]) & m_mask[i]) != '0);
        end
`ifdef VECTOR_SEQUENCER_STOP_ON_ERROR_EN
        for (int i = 0; i < n; i++) begin
            if (err_v[i]) begin
                last = i;
                break;
            end
        end
`endif
        total    = (last + 1) * (LATENCY + 1);
        run_err  = 0;
        ff_valid = 1'b0;
        ff_idx   = 0;

        for (int c = 0; c < total; c++) begin
            v   = c / (LATENCY + 1);
            p   = c % (LATENCY + 1);
            sat = (run_err > CMAX) ? CMAX : run_err;
            checks++;
            if (Busy !== 1'b1 || Done !== 1'b0) begin
                errors++;
                $display("FAIL busy_done c=%0d got busy=%b done=%b exp busy=1 done=0", c, Busy, Done);
            end
            checks++;
            if (StimValid !== (p == 0)) begin
                errors++;
                $display("FAIL stimvalid c=%0d got=%b exp=%b", c, StimValid, (p == 0));
            end
            checks++;
            if (VectorIdx !== AW'(v)) begin
                errors++;
                $display("FAIL vectoridx c=%0d got=%0d exp=%0d", c, VectorIdx, v);
            end
            checks++;
            if (Stim !== m_stim[v]) begin
                errors++;
                $display("FAIL stim c=%0d got=%h exp=%h", c, Stim, m_stim[v]);
            end
            checks++;
            if (ErrorCount !== CNT_W'(sat) || FirstFailValid !== ff_valid ||
                FirstFailIdx !== AW'(ff_idx)) begin
                errors++;
                $display("FAIL running_errs c=%0d got cnt=%0d ffv=%b ffi=%0d exp cnt=%0d ffv=%b ffi=%0d",
                         c, ErrorCount, FirstFailValid, FirstFailIdx, sat, ff_valid, ff_idx);
            end

            // Correct answer only in the compare cycle; disturbed otherwise.
            Observed = (p == LATENCY) ? obs_good[v] : (obs_good[v] ^ m_mask[v]);
            if (abort_at == c) Reset = 1'b0;
            if (poke_busy && c == 1) begin
                Start      = 1'b1;
                NumVectors = (AW + 1)'(1);
                LoadEn     = 1'b1;
                LoadAddr   = '0;
                LoadData   = ~{m_stim[0], m_exp[0], m_mask[0]};
            end
            tick();
            Start  = 1'b0;
            LoadEn = 1'b0;

            if (abort_at == c) begin
                checks++;
                if ({Stim, StimValid, Busy, Done, VectorIdx, ErrorCount, FirstFailValid, FirstFailIdx} !== '0) begin
                    errors++;
                    $display("FAIL abort_outputs got stim=%h sv=%b busy=%b done=%b idx=%0d cnt=%0d ffv=%b ffi=%0d exp all zero",
                             Stim, StimValid, Busy, Done, VectorIdx, ErrorCount, FirstFailValid, FirstFailIdx);
                end
                Reset = 1'b1;
                tick();
                checks++;
                if (Busy !== 1'b0 || Done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle got busy=%b done=%b exp 0 0", Busy, Done);
                end
                return;
            end

            if (p == LATENCY && err_v[v]) begin
                if (!ff_valid) begin
                    ff_valid = 1'b1;
                    ff_idx   = v;
                end
                run_err++;
            end
        end

        sat = (run_err > CMAX) ? CMAX : run_err;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (Done !== 1'b1 || Busy !== 1'b0 || StimValid !== 1'b0) begin
                errors++;
                $display("FAIL done_state k=%0d got done=%b busy=%b sv=%b exp 1 0 0", k, Done, Busy, StimValid);
            end
            checks++;
            if (ErrorCount !== CNT_W'(sat) || FirstFailValid !== ff_valid ||
                FirstFailIdx !== AW'(ff_idx)) begin
                errors++;
                $display("FAIL final_errs k=%0d got cnt=%0d ffv=%b ffi=%0d exp cnt=%0d ffv=%b ffi=%0d",
                         k, ErrorCount, FirstFailValid, FirstFailIdx, sat, ff_valid, ff_idx);
            end
            checks++;
            if (VectorIdx !== AW'((n == 0) ? 0 : last)) begin
                errors++;
                $display("FAIL final_idx k=%0d got=%0d exp=%0d", k, VectorIdx, (n == 0) ? 0 : last);
            end
            if (n > 0) begin
                checks++;
                if (Stim !== m_stim[last]) begin
                    errors++;
                    $display("FAIL final_stim k=%0d got=%h exp=%h", k, Stim, m_stim[last]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({Stim, StimValid, Busy, Done, VectorIdx, ErrorCount, FirstFailValid, FirstFailIdx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got stim=%h sv=%b busy=%b done=%b idx=%0d cnt=%0d ffv=%b ffi=%0d exp all zero",
                     Stim, StimValid, Busy, Done, VectorIdx, ErrorCount, FirstFailValid, FirstFailIdx);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || StimValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b sv=%b exp 0 0 0", Busy, Done, StimValid);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            load(i, rand_stim(), EXP_W'(8'h10 * (i + 1)), 8'hFF);
            obs_good[i] = m_exp[i];
        end
        run(4, 1'b0, 1'b0, -1);
    endtask

    task automatic test_errors();
        obs_good[1] = 8'h33;
        obs_good[3] = 8'h00;
        run(4, 1'b0, 1'b0, -1);
`ifdef VECTOR_SEQUENCER_STOP_ON_ERROR_EN
        checks++;
        if (ErrorCount !== CNT_W'(1) || VectorIdx !== AW'(1)) begin
            errors++;
            $display("FAIL stop_on_error got cnt=%0d idx=%0d exp cnt=1 idx=1", ErrorCount, VectorIdx);
        end
`else
        checks++;
        if (ErrorCount !== CNT_W'(2) || FirstFailIdx !== AW'(1) || FirstFailValid !== 1'b1) begin
            errors++;
            $display("FAIL two_errors got cnt=%0d ffi=%0d ffv=%b exp cnt=2 ffi=1 ffv=1",
                     ErrorCount, FirstFailIdx, FirstFailValid);
        end
`endif
    endtask

    task automatic test_mask();
        load(0, rand_stim(), 8'hA5, 8'h0F);
        obs_good[0] = 8'h35;
        run(1, 1'b0, 1'b0, -1);
        checks++;
        if (ErrorCount !== '0 || FirstFailValid !== 1'b0) begin
            errors++;
            $display("FAIL mask_hidden got cnt=%0d ffv=%b exp cnt=0 ffv=0", ErrorCount, FirstFailValid);
        end
        obs_good[0] = 8'hA4;
        run(1, 1'b0, 1'b0, -1);
        checks++;
        if (ErrorCount !== CNT_W'(1) || FirstFailValid !== 1'b1) begin
            errors++;
            $display("FAIL mask_visible got cnt=%0d ffv=%b exp cnt=1 ffv=1", ErrorCount, FirstFailValid);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            load(i, rand_stim(), EXP_W'($urandom()), EXP_W'($urandom()));
            obs_good[i] = ($urandom_range(0, 2) != 0) ? m_exp[i] : EXP_W'($urandom());
        end
    endtask

    task automatic test_boundaries();
        fill_random();
        run(0, 1'b0, 1'b0, -1);
        run(DEPTH + 5, 1'b0, 1'b0, -1);
        run(DEPTH, 1'b0, 1'b0, -1);
    endtask

    task automatic test_abort();
        fill_random();
        run(4, 1'b0, 1'b0, 2 * (LATENCY + 1));
        run(4, 1'b0, 1'b0, -1);
    endtask

    task automatic test_busy_ignored();
        fill_random();
        run(4, 1'b0, 1'b1, -1);
        run(4, 1'b0, 1'b0, -1);
    endtask

    task automatic test_start_with_load();
        run(3, 1'b1, 1'b0, -1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 6; i++) begin
            load(i, rand_stim(), EXP_W'($urandom()), 8'hFF);
            obs_good[i] = ~m_exp[i];
        end
        run(6, 1'b0, 1'b0, -1);
`ifndef VECTOR_SEQUENCER_STOP_ON_ERROR_EN
        checks++;
        if (ErrorCount !== CNT_W'(CMAX) || FirstFailIdx !== '0) begin
            errors++;
            $display("FAIL saturation got cnt=%0d ffi=%0d exp cnt=%0d ffi=0", ErrorCount, FirstFailIdx, CMAX);
        end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run($urandom_range(0, DEPTH + 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_mask();
        test_boundaries();
        test_abort();
        test_busy_ignored();
        test_start_with_load();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Synthesizable, parametrised test-vector player/checker for the datapath control word (ALU system and its register blocks).
- Holds a loadable vector table of {stimulus, expected, mask} entries and replays them in order.
- For each vector, drives the stimulus to the DUT and compares the DUT's observed output after a fixed latency.
- Accumulates an error count and captures the first failing index; used for on-board self-test and as a bench harness.

Parameters:
STIM_W, 34, stimulus (control word) width
EXP_W, 8, width of observed/expected result
DEPTH, 256, vector table entries (power of two)
LATENCY, 1, cycles from stimulus apply to compare (>=1)
CNT_W, 16, error counter width
AW, $clog2(DEPTH), derived address width (localparam)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-low
LoadEn  in  1  write one table entry this cycle
LoadAddr  in  AW  table write address
LoadData  in  STIM_W+2*EXP_W  {stim, expected, mask}, stim in MSBs
NumVectors  in  AW+1  vectors to run, sampled at Start
Start  in  1  begin run (single-cycle pulse)
Observed  in  EXP_W  DUT result under check
Stim  out  STIM_W  stimulus to DUT
StimValid  out  1  high on first cycle of each vector
Busy  out  1  run in progress
Done  out  1  run finished (sticky)
VectorIdx  out  AW  index of current vector
ErrorCount  out  CNT_W  mismatches in current/last run
FirstFailValid  out  1  at least one mismatch recorded
FirstFailIdx  out  AW  index of first mismatch

Behaviour:
- Reset (sync, Reset==0 at posedge):
  - state IDLE; all outputs 0.
  - Table contents are not cleared.
- Table:
  - Register array, written at posedge when LoadEn=1 and state is IDLE or DONE.
  - LoadEn while Busy is ignored.
  - Read is combinational at VectorIdx.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
  - IDLE/DONE + Start:
    - latch N = min(NumVectors, DEPTH);
    - clear ErrorCount, FirstFailValid, FirstFailIdx, Done, VectorIdx.
    - N==0 -> DONE next cycle; else -> APPLY.
  - APPLY (1 cycle):
    - Stim = table[VectorIdx].stim, StimValid=1, Busy=1.
    - LATENCY==1 -> CHECK; else -> WAIT.
  - WAIT: LATENCY-1 cycles, Stim held, StimValid=0, then -> CHECK.
  - CHECK (1 cycle, LATENCY cycles after APPLY):
    - error = ((Observed ^ expected) & mask) != 0.
    - On error: ErrorCount += 1, saturating at all-ones.
    - On error with FirstFailValid==0: FirstFailIdx = VectorIdx, FirstFailValid = 1.
    - VectorIdx == N-1 -> DONE; else VectorIdx += 1, -> APPLY.
  - DONE:
    - Busy=0, Done=1 (sticky until next Start or reset); Stim holds last value.
    - ErrorCount, FirstFail* hold.
- Timing:
  - Cycles per vector = LATENCY+1; run length = N*(LATENCY+1) cycles from APPLY entry.
  - Busy is high from the cycle after Start until DONE.
- Stimulus stability: Stim changes only on APPLY entry; stable through WAIT and CHECK.
- Start while Busy is ignored.
- Reset asserted mid-run aborts to IDLE with outputs cleared in the same clock edge.
- Start and LoadEn in the same cycle (IDLE): the write is performed, and the run sees the new entry.
- N == DEPTH: VectorIdx reaches DEPTH-1 with no wrap; DONE follows.

Optional Feature:
VECTOR_SEQUENCER_STOP_ON_ERROR_EN
- Defined: first mismatch in CHECK goes directly to DONE. VectorIdx stays at the failing index, ErrorCount=1.
- Undefined: the run always completes all N vectors.

Test Plan:
1. Load 4 vectors (exp 0x10,0x20,0x30,0x40, mask 0xFF); bench echoes the correct value; Start, NumVectors=4, LATENCY=1 -> Done after 8 cycles, ErrorCount=0, FirstFailValid=0, StimValid pulsed 4 times two cycles apart.
2. Same table, bench returns 0x33 for vector 1 and 0x00 for vector 3 -> ErrorCount=2, FirstFailIdx=1. With STOP_ON_ERROR_EN: ErrorCount=1, Done 4 cycles after Start, VectorIdx=1.
3. Mask 0x0F, exp 0xA5, observed 0x35 -> no error; observed 0xA4 -> error.
4. NumVectors=0 -> Done one cycle after Start, Busy never high. NumVectors=DEPTH+5 -> exactly DEPTH CHECK cycles.
5. Reset low at vector 2 -> next cycle all outputs 0, state IDLE. A Start pulse while Busy and a LoadEn while Busy both have no effect, checked by reading back the table on a rerun.
6. CNT_W=2, 6 failing vectors -> ErrorCount saturates at 3.
